obc1_oam_reader: RTL and testbench
==================================

Name: obc1_oam_reader

Overview:
- Read-side counterpart of the OBC1 OAM write path.
- On request, walks the selected OAM bank in order: 512-byte low table, then 32-byte high table.
- Streams the bytes out over a valid/ready byte interface to the MCU/savestate side.
- Uses the spare read ports of the OBC1 low/high OAM RAMs. Never writes OAM.

Parameters:
- LOW_BYTES, 512, number of low-table bytes per bank.
- HIGH_BYTES, 32, number of high-table bytes per bank.

Ports:
- clk  in  1  system clock. Everything is in this domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a dump. Ignored while busy.
- bank  in  1  OBC1 bank to dump. Latched when start is accepted.
- busy  out  1  high from the start-acceptance edge until the last byte is handshaken.
- done  out  1  one-cycle pulse on the edge the last byte is handshaken.
- low_addr  out  10  low OAM RAM read address, {~bank, idx[8:0]}.
- low_data  in  8  low RAM read data, 1-cycle synchronous latency.
- high_addr  out  6  high OAM RAM byte-port address, {~bank, idx[4:0]}.
- high_data  in  8  high RAM read data, 1-cycle latency.
- out_data  out  8  streamed byte.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  sink accepts the byte; a transfer happens when out_valid & out_ready.
- out_last  out  1  qualifies the final byte of the dump.

Behaviour:
- Reset: busy=0, done=0, out_valid=0, out_last=0, out_data=0, low_addr=0, high_addr=0. FIFO is emptied and any in-flight reads are discarded.
- FSM states: IDLE, LOW, HIGH, DRAIN.
  - IDLE -> LOW on start; the edge that accepts start latches bank.
  - LOW issues idx 0..LOW_BYTES-1, then goes to HIGH.
  - HIGH issues idx 0..HIGH_BYTES-1, then goes to DRAIN.
  - DRAIN -> IDLE on the edge the out_last byte transfers; done pulses and busy falls on that same edge.
- Read issue: one address per cycle, only when (FIFO occupancy + in-flight reads) < 2.
  - A tag registered with each issued read selects low_data or high_data on return.
  - Returning data is written into a 2-entry output FIFO.
- Throughput and latency:
  - First out_valid rises 2 edges after start is sampled (E0 accept, E1 capture of returned data, E2 FIFO output valid).
  - With out_ready held high, one byte per cycle after that, with no bubbles, including across the LOW -> HIGH switch.
- Backpressure: out_data and out_last stay stable while out_valid & ~out_ready. No byte is dropped or duplicated.
- Ordering: low[0..511], then high[0..31], for 544 bytes in total. out_last is set only on the final byte.
- Index counter: 10 bits, no wrap. An issue past the table end is impossible by construction; verify with an assertion.
- start while busy: ignored. bank changes while busy: ignored.
- start and a reset in the same cycle: reset wins.
- rst mid-dump: the stream aborts; out_valid drops on the reset edge. No done pulse and no out_last.
- done and a new start in the same cycle: the new start is ignored, because busy is still high on that cycle.

Optional Feature:
- Macro: OBC1_READER_REGS_EN.
- With the macro defined:
  - Adds ports reg_idx out 3 and reg_data in 8. Register reads are combinational, so reg_data is captured at issue time and carries a tag like a RAM read.
  - Adds a REGS state after HIGH that appends OBC1 registers 0..7.
  - Total is 552 bytes, with out_last on register 7.
- Without the macro: no extra ports, no REGS state, 544 bytes in total.

Decomposition:
- Shared package obc1_pkg:
  - FSM state encoding.
  - Table sizes (512, 32, 8).
  - Read-tag encoding (LOW/HIGH/REG).
- One natural sub-module: obc1_reader_fifo2, a 2-entry byte+last FIFO with count output, used as the output skid buffer.

Test Plan:
- Full dump, bank=0, out_ready=1: low RAM filled with addr[7:0] ^ 8'h5A.
  - Required: 544 transfers on consecutive cycles.
  - Byte 0 read from low addr 10'h200; byte 512 read from high addr 6'h20.
  - out_last on byte 543; done one cycle, on that edge.
- bank=1 dump: addresses stay in 10'h000..1FF and 6'h00..1F. Byte sequence matches the model.
- out_ready toggling randomly at 30% duty: the byte sequence is identical to the no-backpressure run, and out_data is stable during stalls.
- start pulsed again at byte 100 with bank flipped: ignored. Stream continues with the original bank; exactly 544 bytes.
- rst asserted at byte 300: out_valid=0 and busy=0 after the edge. No done. A following start restarts the dump at byte 0.
- With OBC1_READER_REGS_EN and regs 0..7 = 8'h10..8'h17: 552 bytes. Bytes 544..551 = 8'h10..8'h17, with out_last on 8'h17.

Source files
------------

// File: rtl/obc1_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | obc1_pkg : shared state, table-size and read-tag encodings (Rev 1.0)       |
// +----------------------------------------------------------------------------+
package obc1_pkg;

  localparam int LOW_TABLE_BYTES  = 512;
  localparam int HIGH_TABLE_BYTES = 32;
  localparam int REG_TABLE_BYTES  = 8;
  localparam int IDX_W            = 10;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOW   = 3'd1,
    ST_HIGH  = 3'd2,
    ST_REGS  = 3'd3,
    ST_DRAIN = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    TAG_LOW  = 2'd0,
    TAG_HIGH = 2'd1,
    TAG_REG  = 2'd2
  } tag_t;

  function automatic logic [IDX_W-1:0] last_idx(input int n);
    return IDX_W'(n - 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/obc1_reader_fifo2.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | obc1_reader_fifo2 : 2-entry byte+last skid FIFO with occupancy (Rev 1.0)   |
// +----------------------------------------------------------------------------+
module obc1_reader_fifo2
  import obc1_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  logic [7:0] push_data,
  input  logic       push_last,
  input  logic       pop,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       out_valid,
  output logic [1:0] count
);

  logic [7:0] r_data [2];
  logic [1:0] r_last;
  logic       r_wr;
  logic       r_rd;
  logic [1:0] r_count;
  logic       w_pop;

  assign out_valid = (r_count != 2'd0);
  assign w_pop     = pop & out_valid;
  assign out_data  = out_valid ? r_data[r_rd] : 8'h00;
  assign out_last  = out_valid & r_last[r_rd];
  assign count     = r_count;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data[0] <= 8'h00;
      r_data[1] <= 8'h00;
      r_last    <= 2'b00;
      r_wr      <= 1'b0;
      r_rd      <= 1'b0;
      r_count   <= 2'd0;
    end else begin
      if (push) begin
        r_data[r_wr] <= push_data;
        r_last[r_wr] <= push_last;
        r_wr         <= ~r_wr;
      end
      if (w_pop) begin
        r_rd <= ~r_rd;
      end
      r_count <= r_count + {1'b0, push} - {1'b0, w_pop};
    end
  end

  // The issuer reserves space ahead of time, so a push never meets a full FIFO.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    push |-> ((r_count != 2'd2) || w_pop));

endmodule
`default_nettype wire

// File: rtl/obc1_oam_reader.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | obc1_oam_reader : streams one OBC1 OAM bank (low, high, optional regs      |
// | via OBC1_READER_REGS_EN) over a valid/ready byte port.        Rev 1.0      |
// +----------------------------------------------------------------------------+
module obc1_oam_reader
  import obc1_pkg::*;
#(
  parameter int LOW_BYTES  = LOW_TABLE_BYTES,
  parameter int HIGH_BYTES = HIGH_TABLE_BYTES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       bank,
  output logic       busy,
  output logic       done,
  output logic [9:0] low_addr,
  input  logic [7:0] low_data,
  output logic [5:0] high_addr,
  input  logic [7:0] high_data,
`ifdef OBC1_READER_REGS_EN
  output logic [2:0] reg_idx,
  input  logic [7:0] reg_data,
`endif
  output logic [7:0] out_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_last
);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] w_idx_max;
  logic             r_bank;
  logic             r_inflight;
  logic             r_ret_last;
  tag_t             r_tag;
  tag_t             w_issue_tag;
  logic             w_issue;
  logic             w_idx_end;
  logic             w_final_table;
  logic             w_pop;
  logic             w_fifo_last;
  logic [1:0]       w_fifo_count;
  logic [2:0]       w_occ;
  logic [7:0]       w_ret_data;
`ifdef OBC1_READER_REGS_EN
  logic [7:0]       r_reg_q;
`endif

  assign w_pop     = out_valid & out_ready;
  assign w_idx_end = (idx == w_idx_max);
  // Occupancy after this edge's pop: lets a read issue every cycle at full rate.
  assign w_occ     = {1'b0, w_fifo_count} + {2'b00, r_inflight} - {2'b00, w_pop};

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    w_idx_max     = '0;
    w_issue_tag   = TAG_LOW;
    w_final_table = 1'b0;
    case (state)
      ST_LOW: begin
        w_idx_max   = last_idx(LOW_BYTES);
        w_issue_tag = TAG_LOW;
      end
      ST_HIGH: begin
        w_idx_max   = last_idx(HIGH_BYTES);
        w_issue_tag = TAG_HIGH;
`ifndef OBC1_READER_REGS_EN
        w_final_table = 1'b1;
`endif
      end
`ifdef OBC1_READER_REGS_EN
      ST_REGS: begin
        w_idx_max     = last_idx(REG_TABLE_BYTES);
        w_issue_tag   = TAG_REG;
        w_final_table = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (start) state_nxt = ST_LOW;
      ST_LOW:   if (w_issue && w_idx_end) state_nxt = ST_HIGH;
`ifdef OBC1_READER_REGS_EN
      ST_HIGH:  if (w_issue && w_idx_end) state_nxt = ST_REGS;
      ST_REGS:  if (w_issue && w_idx_end) state_nxt = ST_DRAIN;
`else
      ST_HIGH:  if (w_issue && w_idx_end) state_nxt = ST_DRAIN;
`endif
      ST_DRAIN: if (w_pop && w_fifo_last) state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != ST_IDLE);
    done      = (state == ST_DRAIN) & w_pop & w_fifo_last;
    w_issue   = 1'b0;
    low_addr  = '0;
    high_addr = '0;
`ifdef OBC1_READER_REGS_EN
    reg_idx   = '0;
`endif
    case (state)
      ST_LOW: begin
        w_issue  = (w_occ < 3'd2);
        low_addr = {~r_bank, idx[8:0]};
      end
      ST_HIGH: begin
        w_issue   = (w_occ < 3'd2);
        high_addr = {~r_bank, idx[4:0]};
      end
`ifdef OBC1_READER_REGS_EN
      ST_REGS: begin
        w_issue = (w_occ < 3'd2);
        reg_idx = idx[2:0];
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_bank     <= 1'b0;
      idx        <= '0;
      r_inflight <= 1'b0;
      r_tag      <= TAG_LOW;
      r_ret_last <= 1'b0;
`ifdef OBC1_READER_REGS_EN
      r_reg_q    <= 8'h00;
`endif
    end else begin
      if ((state == ST_IDLE) && start) begin
        r_bank <= bank;
      end
      if (state_nxt != state) begin
        idx <= '0;
      end else if (w_issue) begin
        idx <= idx + 10'd1;
      end
      r_inflight <= w_issue;
      if (w_issue) begin
        r_tag      <= w_issue_tag;
        r_ret_last <= w_final_table & w_idx_end;
`ifdef OBC1_READER_REGS_EN
        // Register reads are combinational; hold the byte so it returns in step with RAM data.
        r_reg_q    <= reg_data;
`endif
      end
    end
  end

  always_comb begin
    case (r_tag)
      TAG_HIGH: w_ret_data = high_data;
`ifdef OBC1_READER_REGS_EN
      TAG_REG:  w_ret_data = r_reg_q;
`endif
      default:  w_ret_data = low_data;
    endcase
  end

  obc1_reader_fifo2 u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (r_inflight),
    .push_data (w_ret_data),
    .push_last (r_ret_last),
    .pop       (w_pop),
    .out_data  (out_data),
    .out_last  (w_fifo_last),
    .out_valid (out_valid),
    .count     (w_fifo_count)
  );

  assign out_last = w_fifo_last;

  a_idx_in_table : assert property (@(posedge clk) disable iff (rst)
    w_issue |-> (idx <= w_idx_max));

endmodule
`default_nettype wire

// File: tb/tb_obc1_oam_reader.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_obc1_oam_reader : directed self-checking bench for obc1_oam_reader     |
// +----------------------------------------------------------------------------+
module tb_obc1_oam_reader;

`ifdef OBC1_READER_REGS_EN
  localparam int TOTAL = 552;
`else
  localparam int TOTAL = 544;
`endif
  localparam int MAX_CYC = 6000;

  logic       clk = 1'b0;
  logic       rst, start, bank, busy, done;
  logic [9:0] low_addr;
  logic [7:0] low_data;
  logic [5:0] high_addr;
  logic [7:0] high_data;
  logic [7:0] out_data;
  logic       out_valid, out_ready, out_last;
`ifdef OBC1_READER_REGS_EN
  logic [2:0] reg_idx;
  logic [7:0] reg_data;
  assign reg_data = 8'h10 + {5'b00000, reg_idx};
`endif

  always #5 clk = ~clk;

  obc1_oam_reader dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .bank      (bank),
    .busy      (busy),
    .done      (done),
    .low_addr  (low_addr),
    .low_data  (low_data),
    .high_addr (high_addr),
    .high_data (high_data),
`ifdef OBC1_READER_REGS_EN
    .reg_idx   (reg_idx),
    .reg_data  (reg_data),
`endif
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_last  (out_last)
  );

  function automatic logic [7:0] low_pat(input logic [9:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  function automatic logic [7:0] high_pat(input logic [5:0] a);
    return {a[5], 2'b01, a[4:0]} ^ 8'h96;
  endfunction

  // OAM RAMs with one cycle of read latency
  always @(posedge clk) begin
    low_data  <= low_pat(low_addr);
    high_data <= high_pat(high_addr);
  end

  int         addr_bad = 0;
  logic       mon_b9 = 1'b1;
  logic [5:0] prev_high = 6'd0;
  logic [5:0] hi_first = 6'd0;

  always @(negedge clk) begin
    if (low_addr != 10'd0 && low_addr[9] != mon_b9) addr_bad++;
    if (high_addr != 6'd0 && high_addr[5] != mon_b9) addr_bad++;
    if (prev_high == 6'd0 && high_addr != 6'd0) hi_first = high_addr;
    prev_high = high_addr;
  end

  int         checks = 0;
  int         errors = 0;
  logic [7:0] got [0:599];
  int         got_n, last_cnt, last_idx, done_cnt, done_bad, stall_bad, stalls;
  int         first_valid_c, first_xfer_c, last_xfer_c;
  logic [9:0] first_low_addr;

  function automatic logic [7:0] exp_byte(input logic b, input int i);
    if (i < 512) return low_pat({~b, 9'(i)});
    else if (i < 544) return high_pat({~b, 5'(i - 512)});
    else return 8'h10 + 8'(i - 544);
  endfunction

  function automatic int count_mismatch(input logic b, input int n);
    int m;
    m = 0;
    for (int i = 0; i < n && i < 600; i++)
      if (got[i] !== exp_byte(b, i)) m++;
    return m;
  endfunction

  task automatic kick(input logic b);
    @(posedge clk); #1;
    start = 1'b1; bank = b; out_ready = 1'b1; mon_b9 = ~b;
  endtask

  // Sink: records every handshake; ends 4 cycles after done, at abort_at bytes, or on the cycle budget.
  task automatic collect(input int ready_pct, input int restart_at, input logic restart_bank,
                         input int abort_at);
    logic       prev_stall, prev_last, restarted;
    logic [7:0] prev_data;
    int         tail;
    got_n = 0; last_cnt = 0; last_idx = -1; done_cnt = 0; done_bad = 0;
    stall_bad = 0; stalls = 0; first_valid_c = -1; first_xfer_c = -1; last_xfer_c = -1;
    prev_stall = 1'b0; prev_last = 1'b0; prev_data = 8'h00; restarted = 1'b0; tail = -1;
    for (int c = 0; c < MAX_CYC; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      out_ready = (ready_pct >= 100) ? 1'b1 : ($urandom_range(99) < ready_pct);
      if (restart_at >= 0 && !restarted && got_n == restart_at) begin
        start = 1'b1; bank = restart_bank; restarted = 1'b1;
      end
      @(negedge clk);
      if (c == 0) first_low_addr = low_addr;
      if (out_valid && first_valid_c < 0) first_valid_c = c;
      if (prev_stall) begin
        stalls++;
        if (!out_valid || out_data !== prev_data || out_last !== prev_last) stall_bad++;
      end
      if (done) begin
        done_cnt++;
        if (!(out_valid && out_ready && out_last)) done_bad++;
      end
      if (out_valid && out_ready) begin
        if (got_n < 600) got[got_n] = out_data;
        if (first_xfer_c < 0) first_xfer_c = c;
        last_xfer_c = c;
        if (out_last) begin last_cnt++; last_idx = got_n; end
        got_n++;
      end
      prev_stall = out_valid && !out_ready; prev_data = out_data; prev_last = out_last;
      if (abort_at >= 0 && got_n == abort_at) break;
      if (tail < 0 && done) tail = 4;
      else if (tail > 0) tail--;
      if (tail == 0) break;
    end
    start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; start = 1'b1; bank = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b want 0", out_last); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h want 00", out_data); end
    checks++; if (low_addr !== 10'h000) begin errors++; $display("FAIL reset_low_addr: got %h want 000", low_addr); end
    checks++; if (high_addr !== 6'h00) begin errors++; $display("FAIL reset_high_addr: got %h want 00", high_addr); end
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0; bank = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL start_under_rst: busy got %b want 0", busy); end
  endtask

  task automatic test_full_dump_bank0;
    int bad0, mm;
    bad0 = addr_bad;
    kick(1'b0);
    collect(100, -1, 1'b0, -1);
    mm = count_mismatch(1'b0, got_n);
    checks++; if (got_n != TOTAL) begin errors++; $display("FAIL b0_count: got %0d want %0d", got_n, TOTAL); end
    checks++; if (first_valid_c != 2) begin errors++; $display("FAIL b0_latency: got %0d want 2", first_valid_c); end
    checks++; if (last_xfer_c - first_xfer_c != TOTAL - 1) begin errors++;
      $display("FAIL b0_no_bubbles: span %0d want %0d", last_xfer_c - first_xfer_c, TOTAL - 1); end
    checks++; if (mm != 0) begin errors++; $display("FAIL b0_bytes: %0d mismatches want 0", mm); end
    checks++; if (got[512] !== high_pat(6'h20)) begin errors++;
      $display("FAIL b0_byte512: got %h want %h", got[512], high_pat(6'h20)); end
    checks++; if (first_low_addr !== 10'h200) begin errors++; $display("FAIL b0_first_low_addr: got %h want 200", first_low_addr); end
    checks++; if (hi_first !== 6'h20) begin errors++; $display("FAIL b0_first_high_addr: got %h want 20", hi_first); end
    checks++; if (last_cnt != 1 || last_idx != TOTAL - 1) begin errors++;
      $display("FAIL b0_last: count %0d at %0d want 1 at %0d", last_cnt, last_idx, TOTAL - 1); end
    checks++; if (done_cnt != 1 || done_bad != 0) begin errors++;
      $display("FAIL b0_done: pulses %0d misplaced %0d want 1 and 0", done_cnt, done_bad); end
    checks++; if (addr_bad != bad0) begin errors++; $display("FAIL b0_addr_bank: %0d bad addrs want 0", addr_bad - bad0); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL b0_busy_after: got %b want 0", busy); end
  endtask

  task automatic test_bank1;
    int bad0, mm;
    bad0 = addr_bad;
    kick(1'b1);
    collect(100, -1, 1'b1, -1);
    mm = count_mismatch(1'b1, got_n);
    checks++; if (got_n != TOTAL) begin errors++; $display("FAIL b1_count: got %0d want %0d", got_n, TOTAL); end
    checks++; if (mm != 0) begin errors++; $display("FAIL b1_bytes: %0d mismatches want 0", mm); end
    checks++; if (addr_bad != bad0) begin errors++; $display("FAIL b1_addr_range: %0d bad addrs want 0", addr_bad - bad0); end
    checks++; if (last_idx != TOTAL - 1 || done_cnt != 1) begin errors++;
      $display("FAIL b1_last_done: last at %0d done %0d want %0d and 1", last_idx, done_cnt, TOTAL - 1); end
  endtask

  task automatic test_backpressure;
    int mm;
    kick(1'b0);
    collect(30, -1, 1'b0, -1);
    mm = count_mismatch(1'b0, got_n);
    checks++; if (got_n != TOTAL) begin errors++; $display("FAIL bp_count: got %0d want %0d", got_n, TOTAL); end
    checks++; if (mm != 0) begin errors++; $display("FAIL bp_bytes: %0d mismatches want 0", mm); end
    checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable stalls want 0", stall_bad); end
    checks++; if (stalls == 0) begin errors++; $display("FAIL bp_stalled: got %0d stalls want >0", stalls); end
    checks++; if (last_cnt != 1 || done_cnt != 1 || done_bad != 0) begin errors++;
      $display("FAIL bp_last_done: last %0d done %0d bad %0d want 1 1 0", last_cnt, done_cnt, done_bad); end
  endtask

  task automatic test_start_while_busy;
    int bad0, mm;
    bad0 = addr_bad;
    kick(1'b0);
    collect(100, 100, 1'b1, -1);
    mm = count_mismatch(1'b0, got_n);
    checks++; if (got_n != TOTAL) begin errors++; $display("FAIL swb_count: got %0d want %0d", got_n, TOTAL); end
    checks++; if (mm != 0) begin errors++; $display("FAIL swb_bytes: %0d mismatches want 0", mm); end
    checks++; if (addr_bad != bad0) begin errors++; $display("FAIL swb_bank_kept: %0d bad addrs want 0", addr_bad - bad0); end
    checks++; if (done_cnt != 1) begin errors++; $display("FAIL swb_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_done_start_collision;
    kick(1'b1);
    collect(100, TOTAL - 1, 1'b0, -1);
    checks++; if (got_n != TOTAL) begin errors++; $display("FAIL dsc_count: got %0d want %0d", got_n, TOTAL); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL dsc_start_ignored: busy got %b want 0", busy); end
  endtask

  task automatic test_reset_mid_dump;
    int mm;
    kick(1'b0);
    collect(100, -1, 1'b0, 300);
    checks++; if (got_n != 300 || done_cnt != 0 || last_cnt != 0) begin errors++;
      $display("FAIL rmd_pre: bytes %0d done %0d last %0d want 300 0 0", got_n, done_cnt, last_cnt); end
    @(posedge clk); #1;
    rst = 1'b1; out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin errors++;
      $display("FAIL rmd_after_rst: valid %b busy %b done %b want 0 0 0", out_valid, busy, done); end
    @(posedge clk); #1;
    rst = 1'b0;
    kick(1'b0);
    collect(100, -1, 1'b0, -1);
    mm = count_mismatch(1'b0, got_n);
    checks++; if (got_n != TOTAL || mm != 0) begin errors++;
      $display("FAIL rmd_restart: bytes %0d mismatches %0d want %0d and 0", got_n, mm, TOTAL); end
    checks++; if (got[0] !== exp_byte(1'b0, 0)) begin errors++;
      $display("FAIL rmd_byte0: got %h want %h", got[0], exp_byte(1'b0, 0)); end
  endtask

`ifdef OBC1_READER_REGS_EN
  task automatic test_regs;
    kick(1'b0);
    collect(100, -1, 1'b0, -1);
    checks++; if (got_n != 552) begin errors++; $display("FAIL regs_count: got %0d want 552", got_n); end
    checks++; if (got[544] !== 8'h10) begin errors++; $display("FAIL regs_first: got %h want 10", got[544]); end
    checks++; if (got[551] !== 8'h17) begin errors++; $display("FAIL regs_last_byte: got %h want 17", got[551]); end
    checks++; if (last_idx != 551 || last_cnt != 1) begin errors++;
      $display("FAIL regs_last_flag: at %0d count %0d want 551 and 1", last_idx, last_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_full_dump_bank0();
    test_bank1();
    test_backpressure();
    test_start_while_busy();
    test_done_start_collision();
    test_reset_mid_dump();
`ifdef OBC1_READER_REGS_EN
    test_regs();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
